rs_issue_arbiter: RTL and testbench

//  Issue scheduler between the reservation station (RS) and the functional units.

---
 rtl/rs_issue_arbiter.sv | 122 ++++++++++++
 tb/tb_rs_issue_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rs_issue_arbiter.sv
// Round-robin issue arbiter from the reservation station to ALUs, multiplier and memory unit.
// Grants are combinational; only the scan pointer and multiplier occupancy are stored.
module rs_issue_arbiter #(
   parameter int NUM_REQ   = 8,
   parameter int NUM_ALU   = 2,
   parameter int MULT_LAT  = 4,
   parameter int NUM_ISSUE = 3,
   localparam int IW = $clog2(NUM_REQ),
   localparam int CW = $clog2(MULT_LAT) + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [2*NUM_REQ-1:0]  req_type,
   input  logic                  mem_ready,
   input  logic                  squash,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_ALU-1:0]    alu_go,
   output logic [NUM_ALU*IW-1:0] alu_idx,
   output logic                  mult_go,
   output logic [IW-1:0]         mult_idx,
   output logic                  mem_go,
   output logic [IW-1:0]         mem_idx,
   output logic                  mult_busy,
   output logic                  mult_done
);

   logic [IW-1:0] rr_ptr;
   logic [CW-1:0] mult_cnt;
   logic [IW-1:0] idx;
   logic [IW-1:0] last;
   logic [1:0]    typ;
   logic          any;
   logic          placed;
   logic          active;
   int            ngr;

   assign active = reset && !squash;

   always_comb begin
      grant    = '0;
      alu_go   = '0;
      alu_idx  = '0;
      mult_go  = 1'b0;
      mult_idx = '0;
      mem_go   = 1'b0;
      mem_idx  = '0;
      idx      = '0;
      typ      = '0;
      last     = '0;
      any      = 1'b0;
      placed   = 1'b0;
      ngr      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = rr_ptr + IW'(i);
         typ = req_type[{idx, 1'b0} +: 2];
         if (active && req_valid[idx] && ngr < NUM_ISSUE) begin
            unique case (typ)
               2'b00: begin
                  placed = 1'b0;
                  for (int k = 0; k < NUM_ALU; k++) begin
                     if (!placed && !alu_go[k]) begin
                        alu_go[k]             = 1'b1;
                        alu_idx[k*IW +: IW]   = idx;
                        placed                = 1'b1;
                     end
                  end
                  if (placed) begin
                     grant[idx] = 1'b1;
                     last       = idx;
                     any        = 1'b1;
                     ngr        = ngr + 1;
                  end
               end
               2'b01: begin
                  if (mult_cnt == '0 && !mult_go) begin
                     mult_go    = 1'b1;
                     mult_idx   = idx;
                     grant[idx] = 1'b1;
                     last       = idx;
                     any        = 1'b1;
                     ngr        = ngr + 1;
                  end
               end
               2'b10: begin
                  if (mem_ready && !mem_go) begin
                     mem_go     = 1'b1;
                     mem_idx    = idx;
                     grant[idx] = 1'b1;
                     last       = idx;
                     any        = 1'b1;
                     ngr        = ngr + 1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign mult_busy = reset && (mult_cnt != '0);
   assign mult_done = active && (mult_cnt == CW'(1));

   // Squash abandons any in-flight multiply and restarts the scan at entry 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr   <= '0;
         mult_cnt <= '0;
      end else if (squash) begin
         rr_ptr   <= '0;
         mult_cnt <= '0;
      end else begin
         if (any)
            rr_ptr <= last + 1'b1;
         if (mult_go)
            mult_cnt <= CW'(MULT_LAT - 1);
         else if (mult_cnt != '0)
            mult_cnt <= mult_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Directed bench for rs_issue_arbiter: a vector table walked cycle by cycle,
// followed by hand-written multiply cadence, squash and async-reset sequences.
module tb_rs_issue_arbiter;

   logic        clock;
   logic        reset;
   logic [7:0]  req_valid;
   logic [15:0] req_type;
   logic        mem_ready;
   logic        squash;
   logic [7:0]  grant;
   logic [1:0]  alu_go;
   logic [5:0]  alu_idx;
   logic        mult_go;
   logic [2:0]  mult_idx;
   logic        mem_go;
   logic [2:0]  mem_idx;
   logic        mult_busy;
   logic        mult_done;

   int n_pass;
   int n_total;

   rs_issue_arbiter dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_type  (req_type),
      .mem_ready (mem_ready),
      .squash    (squash),
      .grant     (grant),
      .alu_go    (alu_go),
      .alu_idx   (alu_idx),
      .mult_go   (mult_go),
      .mult_idx  (mult_idx),
      .mem_go    (mem_go),
      .mem_idx   (mem_idx),
      .mult_busy (mult_busy),
      .mult_done (mult_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        sq;
      logic        mr;
      logic [7:0]  v;
      logic [15:0] t;
      logic [7:0]  g;
      logic [1:0]  ag;
      logic [5:0]  ai;
      logic        mg;
      logic [2:0]  mi;
      logic        eg;
      logic [2:0]  ei;
      logic        bz;
      logic        dn;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic rst, input logic sq, input logic mr,
                        input logic [7:0] v, input logic [15:0] t);
      @(negedge clock);
      reset     = rst;
      squash    = sq;
      mem_ready = mr;
      req_valid = v;
      req_type  = t;
      #1;
   endtask

   task automatic expect_all(input string tag, input logic [7:0] g,
                             input logic [1:0] ag, input logic [5:0] ai,
                             input logic mg, input logic [2:0] mi,
                             input logic eg, input logic [2:0] ei,
                             input logic bz, input logic dn);
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".alu_go"}, 32'(alu_go), 32'(ag));
      chk({tag, ".alu_idx"}, 32'(alu_idx), 32'(ai));
      chk({tag, ".mult_go"}, 32'(mult_go), 32'(mg));
      chk({tag, ".mult_idx"}, 32'(mult_idx), 32'(mi));
      chk({tag, ".mem_go"}, 32'(mem_go), 32'(eg));
      chk({tag, ".mem_idx"}, 32'(mem_idx), 32'(ei));
      chk({tag, ".mult_busy"}, 32'(mult_busy), 32'(bz));
      chk({tag, ".mult_done"}, 32'(mult_done), 32'(dn));
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      reset     = 1'b0;
      squash    = 1'b0;
      mem_ready = 1'b0;
      req_valid = '0;
      req_type  = '0;

      //          rst  sq   mr   valid        types     grant        ag     alu_idx    mg   mi    eg   ei    bz   dn
      tbl[0]  = '{1'b0,1'b0,1'b0,8'hFF,       16'h0000, 8'h00,       2'b00, 6'o00,     1'b0,3'd0,1'b0,3'd0,1'b0,1'b0};
      tbl[1]  = '{1'b1,1'b0,1'b0,8'hFF,       16'h0000, 8'b0000_0011,2'b11, 6'o10,     1'b0,3'd0,1'b0,3'd0,1'b0,1'b0};
      tbl[2]  = '{1'b1,1'b1,1'b1,8'hFF,       16'h0000, 8'h00,       2'b00, 6'o00,     1'b0,3'd0,1'b0,3'd0,1'b0,1'b0};
      tbl[3]  = '{1'b1,1'b0,1'b0,8'b0010_0110,16'h0000, 8'b0000_0110,2'b11, 6'o21,     1'b0,3'd0,1'b0,3'd0,1'b0,1'b0};
      tbl[4]  = '{1'b1,1'b0,1'b0,8'b0010_0000,16'h0000, 8'b0010_0000,2'b01, 6'o05,     1'b0,3'd0,1'b0,3'd0,1'b0,1'b0};
      tbl[5]  = '{1'b1,1'b0,1'b1,8'b1000_0111,16'h0024, 8'b1000_0011,2'b11, 6'o07,     1'b1,3'd1,1'b0,3'd0,1'b0,1'b0};
      tbl[6]  = '{1'b1,1'b0,1'b0,8'b0000_1000,16'h0080, 8'h00,       2'b00, 6'o00,     1'b0,3'd0,1'b0,3'd0,1'b1,1'b0};
      tbl[7]  = '{1'b1,1'b0,1'b1,8'b0000_1000,16'h0080, 8'b0000_1000,2'b00, 6'o00,     1'b0,3'd0,1'b1,3'd3,1'b1,1'b0};
      tbl[8]  = '{1'b1,1'b0,1'b0,8'h00,       16'h0000, 8'h00,       2'b00, 6'o00,     1'b0,3'd0,1'b0,3'd0,1'b1,1'b1};
      tbl[9]  = '{1'b1,1'b0,1'b0,8'b0001_0000,16'h0100, 8'b0001_0000,2'b00, 6'o00,     1'b1,3'd4,1'b0,3'd0,1'b0,1'b0};
      tbl[10] = '{1'b1,1'b0,1'b0,8'b0110_0000,16'h0C00, 8'b0100_0000,2'b01, 6'o06,     1'b0,3'd0,1'b0,3'd0,1'b1,1'b0};

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].sq, tbl[i].mr, tbl[i].v, tbl[i].t);
         expect_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].ag, tbl[i].ai,
                    tbl[i].mg, tbl[i].mi, tbl[i].eg, tbl[i].ei,
                    tbl[i].bz, tbl[i].dn);
      end

      // Clear state, then two multiplies back to back: cadence of 4 cycles
      drive(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000);
      expect_all("clr", 8'h00, 2'b00, 6'o00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'b0101_0000, 16'h1100);
      expect_all("mul.c0", 8'b0001_0000, 2'b00, 6'o00, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'b0100_0000, 16'h1100);
      expect_all("mul.c1", 8'h00, 2'b00, 6'o00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'b0100_0000, 16'h1100);
      expect_all("mul.c2", 8'h00, 2'b00, 6'o00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'b0100_0000, 16'h1100);
      expect_all("mul.c3", 8'h00, 2'b00, 6'o00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 8'b0100_0000, 16'h1100);
      expect_all("mul.c4", 8'b0100_0000, 2'b00, 6'o00, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0);

      // Squash during the second multiply with ALU requests pending
      drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
      expect_all("sq.c1", 8'h00, 2'b00, 6'o00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'b0000_0011, 16'h0000);
      expect_all("sq.c2", 8'h00, 2'b00, 6'o00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
      expect_all("sq.c3", 8'h00, 2'b00, 6'o00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'b1000_0001, 16'h0000);
      expect_all("sq.ptr", 8'b1000_0001, 2'b11, 6'o70, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a multiply
      drive(1'b1, 1'b0, 1'b0, 8'b0000_0100, 16'h0010);
      expect_all("ar.go", 8'b0000_0100, 2'b00, 6'o00, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
      chk("ar.busy_before", 32'(mult_busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("ar.busy_after", 32'(mult_busy), 32'd0);
      chk("ar.done_after", 32'(mult_done), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
      expect_all("ar.rel", 8'h00, 2'b00, 6'o00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
